sid_write_sched: RTL
====================

// Module: sid_write_sched
// PURPOSE
//  Arbitrates and paces writes into the SID register port (we/addr/wdata).
//  Requester A: the C64 bus interface; single-cycle strobes, highest priority, never stalled.
//  Requester B: a host command stream (SPI/USB) held in a FIFO and replayed on SID ticks (clk_en).
//  B supports timed delay entries, so register dumps play back with correct timing.
// PARAMETERS
//  FIFO_AW   4   B FIFO address width; depth = 2**FIFO_AW (16)
//  DLY_W     13  width of the delay count in a B delay entry
// PORTS
//  clk         in   1        system clock
//  rst         in   1        asynchronous reset, active-high
//  clk_en      in   1        SID 1 MHz tick; one clk-cycle pulse
//  a_we        in   1        A write strobe
//  a_addr      in   5        A register address
//  a_wdata     in   8        A write data
//  b_valid     in   1        B entry valid
//  b_ready     out  1        B entry accepted when b_valid & b_ready
//  b_data      in   14       [13]=0: write {[12:8]=addr,[7:0]=data}; [13]=1: delay N=[12:0] ticks
//  flush       in   1        synchronous: discard B FIFO and abort any delay
//  sid_we      out  1        write strobe to SID, one cycle
//  sid_addr    out  5        register address of issued write
//  sid_wdata   out  8        data of issued write
//  busy        out  1        FIFO non-empty or state DELAY
//  fifo_level  out  FIFO_AW+1  current B FIFO occupancy
// BEHAVIOUR
//  Reset (async): sid_we/sid_addr/sid_wdata=0, FIFO empty, state IDLE, delay cnt=0, busy=0, level=0.
//   b_ready=0 while rst is high.
//  Outputs are registered. Any issued write shows sid_we=1 the cycle after its decision cycle.
//   sid_addr/sid_wdata hold their last values between strobes.
//  A path: a_we=1 in cycle t -> sid_we=1 with a_addr/a_wdata in t+1. Independent of clk_en and state.
//  B push: b_ready = !full & !flush. The push happens on b_valid & b_ready.
//   When full, b_ready=0 even if a pop occurs in the same cycle.
//   Push and pop in the same cycle leave level unchanged.
//  B eligible cycle: state IDLE & FIFO non-empty & clk_en=1 & a_we=0 & flush=0.
//   If a_we collides with an eligible cycle, B is deferred to the next clk_en. A is never delayed.
//  States:
//   IDLE, on an eligible cycle, pop the head entry:
//    write entry -> issue it (sid_we next cycle), stay IDLE.
//    delay N=0   -> no write, stay IDLE (the entry consumes that tick).
//    delay N>0   -> cnt<=N, go to DELAY.
//   DELAY: on each clk_en, cnt<=cnt-1. When cnt reaches 0, go to IDLE.
//    a_we does not stall the countdown. No B pops happen in DELAY.
//  Timing: consecutive B writes are issued on consecutive ticks.
//   write, delay N, write -> the second write goes out N+2 ticks after the first (any N >= 0).
//  flush=1: FIFO pointers cleared, level=0, state IDLE, cnt=0, in the next cycle.
//   A push in the flush cycle is dropped. A write issued in the flush cycle still completes.
//  Reset mid-DELAY or mid-FIFO: everything returns to reset values at once. No pending write is emitted.
//  Pointers wrap modulo 2**FIFO_AW. level is exact: 0..2**FIFO_AW.
// TESTING
//  1 Reset: rst 1->0 -> sid_we=0, sid_addr=0, level=0, busy=0, b_ready=1 one cycle after release.
//  2 A write: a_we, addr=0x18, data=0x0F, clk_en=0 -> next cycle sid_we=1, addr 0x18, data 0x0F, for exactly 1 cycle.
//  3 Push writes 0x00=0x12, 0x01=0x34, 0x04=0x21 -> issued in order, one cycle after 3 consecutive clk_en pulses.
//  4 Push write 0x05=0x09, delay 10, write 0x06=0xF0 -> second sid_we exactly 12 ticks after the first; busy drops after it.
//  5 a_we (0x0B=0x41) on the same cycle as an eligible B tick (B head 0x0C=0x22) -> A issued first, B issued after the next clk_en.
//  6 clk_en=0, push 17 entries -> level=16 and b_ready=0 after the 16th; flush -> level=0, busy=0, no sid_we;
//    then rst asserted mid-DELAY -> no write, state IDLE.

Source files
------------

// File: rtl/sid_write_sched_if.sv
// Bus bundle between the write scheduler and its environment.
// The slave modport is the scheduler's view; master is the environment's.
interface sid_write_sched_if #(
    parameter int unsigned FIFO_AW = 4,
    parameter int unsigned DLY_W   = 13
);
    logic               clk_en;
    logic               a_we;
    logic [4:0]         a_addr;
    logic [7:0]         a_wdata;
    logic               b_valid;
    logic               b_ready;
    logic [DLY_W:0]     b_data;
    logic               flush;
    logic               sid_we;
    logic [4:0]         sid_addr;
    logic [7:0]         sid_wdata;
    logic               busy;
    logic [FIFO_AW:0]   fifo_level;

    modport slave (
        input  clk_en, a_we, a_addr, a_wdata, b_valid, b_data, flush,
        output b_ready, sid_we, sid_addr, sid_wdata, busy, fifo_level
    );

    modport master (
        output clk_en, a_we, a_addr, a_wdata, b_valid, b_data, flush,
        input  b_ready, sid_we, sid_addr, sid_wdata, busy, fifo_level
    );
endinterface

// File: rtl/sid_write_sched.sv
// SID register-port write scheduler: bus writes (A) pass straight through,
// host command stream (B) is buffered and replayed on SID ticks with timed delays.
module sid_write_sched #(
    parameter int unsigned FIFO_AW = 4,
    parameter int unsigned DLY_W   = 13
) (
    input  logic             clk,
    input  logic             rst,
    sid_write_sched_if.slave bus
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned LW    = FIFO_AW + 1;
    localparam int unsigned EW    = DLY_W + 1;

    typedef enum logic {S_IDLE, S_DELAY} state_e;

    state_e               state_q, state_d;
    logic [DLY_W-1:0]     cnt_q, cnt_d;
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 sid_we_q, sid_we_d;
    logic [4:0]           sid_addr_q, sid_addr_d;
    logic [7:0]           sid_wdata_q, sid_wdata_d;
    logic                 busy_q, busy_d;
    logic [EW-1:0]        mem_q [DEPTH];

    logic                 full_c;
    logic                 b_ready_c;
    logic                 push_c;
    logic                 pop_c;
    logic [EW-1:0]        head_c;

    assign full_c    = (level_q == LW'(DEPTH));
    assign b_ready_c = !rst && !full_c && !bus.flush;
    assign push_c    = bus.b_valid && b_ready_c;
    assign head_c    = mem_q[rd_ptr_q];

    // Next-state, FIFO bookkeeping and issued-write selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        sid_we_d    = 1'b0;
        sid_addr_d  = sid_addr_q;
        sid_wdata_d = sid_wdata_q;
        pop_c       = 1'b0;

        if (bus.a_we) begin
            sid_we_d    = 1'b1;
            sid_addr_d  = bus.a_addr;
            sid_wdata_d = bus.a_wdata;
        end

        case (state_q)
            S_IDLE: begin
                // A colliding with a tick pushes B out to the next tick.
                if (bus.clk_en && !bus.a_we && !bus.flush && (level_q != '0)) begin
                    pop_c = 1'b1;
                    if (!head_c[DLY_W]) begin
                        sid_we_d    = 1'b1;
                        sid_addr_d  = head_c[12:8];
                        sid_wdata_d = head_c[7:0];
                    end else if (head_c[DLY_W-1:0] != '0) begin
                        cnt_d   = head_c[DLY_W-1:0];
                        state_d = S_DELAY;
                    end
                end
            end
            S_DELAY: begin
                if (bus.clk_en) begin
                    cnt_d = cnt_q - DLY_W'(1);
                    if (cnt_q == DLY_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push_c) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        level_d = level_q + LW'(push_c) - LW'(pop_c);

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            state_d  = S_IDLE;
            cnt_d    = '0;
        end

        busy_d = (level_d != '0) || (state_d == S_DELAY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            sid_we_q    <= 1'b0;
            sid_addr_q  <= '0;
            sid_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            sid_we_q    <= sid_we_d;
            sid_addr_q  <= sid_addr_d;
            sid_wdata_q <= sid_wdata_d;
            busy_q      <= busy_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= bus.b_data;
        end
    end

    assign bus.b_ready    = b_ready_c;
    assign bus.sid_we     = sid_we_q;
    assign bus.sid_addr   = sid_addr_q;
    assign bus.sid_wdata  = sid_wdata_q;
    assign bus.busy       = busy_q;
    assign bus.fifo_level = level_q;
endmodule
